ysyx_24110015_axi_sram: RTL
===========================

YSYX_24110015_AXI_SRAM -- requirements
Module: ysyx_24110015_axi_sram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 4096, number of 32-bit words.
REQ-003 SHALL have parameter RD_LAT, default 1 (legal 1..15), cycles from AR handshake to rvalid.
REQ-004 SHALL have parameter WR_LAT, default 1 (legal 1..15), cycles from last of AW/W handshakes to bvalid.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports araddr in 32 / arvalid in 1 / arready out 1  read address channel.
REQ-008 SHALL have ports rdata out 32 / rresp out 2 / rvalid out 1 / rready in 1  read data channel.
REQ-009 SHALL have ports awaddr in 32 / awvalid in 1 / awready out 1  write address channel.
REQ-010 SHALL have ports wdata in 32 / wstrb in 4 / wvalid in 1 / wready out 1  write data channel.
REQ-011 SHALL have ports bresp out 2 / bvalid out 1 / bready in 1  write response channel.

Function
REQ-012 SHALL be the memory slave consuming the LSU data-port AXI-lite requests; one outstanding read and one outstanding write at a time.
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE; arvalid ignored outside R_IDLE (master holds it high until R handshake).
REQ-014 arvalid&arready in cycle T SHALL capture araddr, go to R_WAIT, load counter; rvalid SHALL rise in cycle T+RD_LAT (+extra, REQ-026).
REQ-015 In R_RESP rvalid, rdata, rresp SHALL stay stable until rvalid&rready; FSM then returns to R_IDLE next cycle.
REQ-016 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; AW and W captured independently in W_IDLE, awready=1 until AW captured, wready=1 until W captured.
REQ-017 AW and W arriving same cycle SHALL both be captured that cycle; W before AW (or reverse) SHALL be legal.
REQ-018 When both captured, SHALL enter W_WAIT; commit write on entry to W_RESP, i.e. WR_LAT (+extra) cycles after the later handshake; bvalid held until bvalid&bready, then W_IDLE.
REQ-019 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; reads always return full word.
REQ-020 Write SHALL update only byte lanes with wstrb[i]=1; wstrb=0 SHALL leave word unchanged and return OKAY.
REQ-021 addr < BASE_ADDR or index >= DEPTH SHALL return resp 2'b11 (DECERR), rdata 0, no memory change; in-range returns 2'b00.
REQ-022 rdata SHALL be sampled on entry to R_RESP; same-cycle write commit to same word SHALL NOT be visible to that read (read returns old data).
REQ-023 Counters SHALL be 4-bit, count down to 1, no wrap; RD_LAT=1 means R_WAIT lasts exactly one cycle.

Reset
REQ-024 While rst=0: arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp = bresp = 0; FSMs to IDLE, captured flags cleared; first cycle after rst=1: arready=awready=wready=1.
REQ-025 Reset mid-transaction SHALL abort it; an uncommitted write SHALL NOT modify memory; memory contents SHALL NOT be reset.

Configuration
REQ-026 Macro AXI_SRAM_RAND_DELAY_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset, steps every cycle) SHALL add lfsr[2:0] extra cycles (0..7), sampled at AR handshake / at write-capture completion; undefined: latency exactly RD_LAT / WR_LAT, no LFSR logic.

Verification
REQ-027 Reset, then write awaddr=32'h8000_0010, wdata=32'hDEAD_BEEF, wstrb=4'hF, AW&W same cycle -> bvalid after WR_LAT, bresp=00; read same address -> rdata=32'hDEAD_BEEF, rresp=00, rvalid at T+RD_LAT.
REQ-028 Over prior word, write wdata=32'h1122_3344 wstrb=4'b0101 -> read returns 32'hDE22_BE44.
REQ-029 W handshake 3 cycles before AW -> single write committed, one bvalid pulse; awready low after AW, wready low after W until bvalid&bready.
REQ-030 Read araddr=32'h7FFF_FFFC and 32'h8000_4000 (DEPTH=4096) -> rresp=11, rdata=0; write to same -> bresp=11, memory unchanged.
REQ-031 Hold rready=0 for 5 cycles in R_RESP with arvalid held high -> rvalid/rdata stable, no second AR accepted; rready=1 -> R_IDLE next cycle.
REQ-032 Assert rst=0 one cycle after AW/W capture (WR_LAT=4) -> no bvalid, target word unchanged on later read; with AXI_SRAM_RAND_DELAY_EN, rvalid delay within RD_LAT..RD_LAT+7.

Source files
------------

// File: rtl/ysyx_24110015_axi_sram.sv
// AXI-lite word-addressed SRAM slave with one outstanding read and one outstanding write.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra cycles to each access latency.
module ysyx_24110015_axi_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AXI_SRAM_RAND_DELAY_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif

  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_DECERR = 2'b11;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] word;
    word = (a - BASE_ADDR) >> 2;
    return (a >= BASE_ADDR) && (word < 32'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] word;
    word = (a - BASE_ADDR) >> 2;
    return IW'(word);
  endfunction

  logic [CW-1:0] extra;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, advanced every cycle
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = CW'(lfsr[2:0]);
`else
  assign extra = '0;
`endif

  // Read channel
  logic [1:0]    r_state, r_next;
  logic [CW-1:0] r_cnt, r_cnt_next;
  logic [IW-1:0] r_idx;
  logic          r_err;
  logic          ar_hs;

  assign ar_hs = arvalid & arready;

  always_comb begin
    r_next     = r_state;
    r_cnt_next = r_cnt;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_next     = R_WAIT;
        r_cnt_next = CW'(RD_LAT) + extra;
      end
      R_WAIT: begin
        if (r_cnt <= CW'(1)) r_next = R_RESP;
        else                 r_cnt_next = r_cnt - CW'(1);
      end
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // rdata is sampled as R_WAIT hands over to R_RESP, so a commit on that same edge stays invisible
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_RESP);
      if (ar_hs) begin
        r_idx <= addr_idx(araddr);
        r_err <= !addr_ok(araddr);
      end
      if (r_state == R_WAIT && r_next == R_RESP) begin
        rdata <= r_err ? 32'd0 : mem[r_idx];
        rresp <= r_err ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  // Write channel
  logic [1:0]    w_state, w_next;
  logic [CW-1:0] w_cnt, w_cnt_next;
  logic          aw_done, aw_done_next, wd_done, wd_done_next;
  logic [IW-1:0] w_idx;
  logic          w_err;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          aw_hs, w_hs, w_enter_resp;

  assign aw_hs        = awvalid & awready;
  assign w_hs         = wvalid & wready;
  assign w_enter_resp = (w_state == W_WAIT) && (w_next == W_RESP);

  always_comb begin
    w_next       = w_state;
    w_cnt_next   = w_cnt;
    aw_done_next = aw_done;
    wd_done_next = wd_done;
    case (w_state)
      W_IDLE: begin
        aw_done_next = aw_done | aw_hs;
        wd_done_next = wd_done | w_hs;
        if (aw_done_next && wd_done_next) begin
          w_next     = W_WAIT;
          w_cnt_next = CW'(WR_LAT) + extra;
        end
      end
      W_WAIT: begin
        if (w_cnt <= CW'(1)) w_next = W_RESP;
        else                 w_cnt_next = w_cnt - CW'(1);
      end
      W_RESP: if (bready) begin
        w_next       = W_IDLE;
        aw_done_next = 1'b0;
        wd_done_next = 1'b0;
      end
      default: begin
        w_next       = W_IDLE;
        aw_done_next = 1'b0;
        wd_done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_done <= 1'b0;
      wd_done <= 1'b0;
      w_idx   <= '0;
      w_err   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      w_cnt   <= w_cnt_next;
      aw_done <= aw_done_next;
      wd_done <= wd_done_next;
      awready <= (w_next == W_IDLE) && !aw_done_next;
      wready  <= (w_next == W_IDLE) && !wd_done_next;
      bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_idx <= addr_idx(awaddr);
        w_err <= !addr_ok(awaddr);
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_enter_resp) bresp <= w_err ? RESP_DECERR : RESP_OKAY;
    end
  end

  // Storage is never reset; a reset before commit drops the pending write
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
